// File: rtl/tb_mem_writer.sv
// Survivor memory write side: packs ACS decision chunks into 64-bit words, writes the
// circular traceback RAM and schedules traceback segments (normal and final flush).
module tb_mem_writer #(
  parameter int W_TB_LEN = 6,
  parameter int TB_LEN   = 32
) (
  input  logic                clk_i,
  input  logic                rst_an_i,
  input  logic                rst_sync_i,
  input  logic                frame_start_i,
  input  logic [1:0]          register_num_i,
  input  logic                dec_valid_i,
  input  logic [7:0]          dec_i,
  input  logic                dec_last_i,
  input  logic [5:0]          best_state_i,
  output logic                dec_ready_o,
  output logic                wr_o,
  output logic [W_TB_LEN-1:0] waddr_o,
  output logic [63:0]         wdata_o,
  input  logic                tb_busy_i,
  output logic                segment_start_o,
  output logic [5:0]          start_state_index_o,
  output logic [W_TB_LEN-1:0] tb_start_addr_o,
  output logic [W_TB_LEN:0]   tb_len_o,
  output logic                decodeing_end_o
);

  localparam int LW = W_TB_LEN + 1;

  logic [1:0]          reg_num;
  logic [2:0]          chunk_cnt;
  logic [63:0]         word;
  logic [W_TB_LEN-1:0] wptr;
  logic [LW-1:0]       und_cnt;
  logic                pending;
  logic [5:0]          pend_state, held_state;
  logic [W_TB_LEN-1:0] pend_addr, held_addr;
  logic [LW-1:0]       pend_len, held_len;
  logic                pend_end, held_end;

  logic          clr, accept, step_done, launch;
  logic [2:0]    last_cnt;
  logic [63:0]   word_next;
  logic [LW-1:0] und_next;

  always_comb begin
    clr       = frame_start_i | rst_sync_i;
    accept    = dec_valid_i & ~pending & ~clr;
    last_cnt  = 3'd7 >> reg_num;
    step_done = accept & (chunk_cnt == last_cnt);
    word_next = word | (64'(dec_i) << {chunk_cnt, 3'b000});
    und_next  = und_cnt + LW'(1);
    // Launch waits until the write of the segment's newest step has left the port.
    launch    = pending & ~wr_o & ~tb_busy_i & ~clr;
  end

  assign dec_ready_o         = ~pending;
  assign segment_start_o     = launch;
  assign start_state_index_o = launch ? pend_state : held_state;
  assign tb_start_addr_o     = launch ? pend_addr  : held_addr;
  assign tb_len_o            = launch ? pend_len   : held_len;
  assign decodeing_end_o     = launch ? pend_end   : held_end;

  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      reg_num    <= 2'b00;
      chunk_cnt  <= '0;
      word       <= '0;
      wptr       <= '0;
      und_cnt    <= '0;
      pending    <= 1'b0;
      pend_state <= '0;
      pend_addr  <= '0;
      pend_len   <= '0;
      pend_end   <= 1'b0;
      held_state <= '0;
      held_addr  <= '0;
      held_len   <= '0;
      held_end   <= 1'b0;
      wr_o       <= 1'b0;
      waddr_o    <= '0;
      wdata_o    <= '0;
    end else if (clr) begin
      reg_num    <= rst_sync_i ? 2'b00 : register_num_i;
      chunk_cnt  <= '0;
      word       <= '0;
      wptr       <= '0;
      und_cnt    <= '0;
      pending    <= 1'b0;
      pend_state <= '0;
      pend_addr  <= '0;
      pend_len   <= '0;
      pend_end   <= 1'b0;
      held_state <= '0;
      held_addr  <= '0;
      held_len   <= '0;
      held_end   <= 1'b0;
      wr_o       <= 1'b0;
      waddr_o    <= '0;
      wdata_o    <= '0;
    end else begin
      wr_o <= step_done;
      if (accept) begin
        if (step_done) begin
          chunk_cnt <= '0;
          word      <= '0;
          wdata_o   <= word_next;
          waddr_o   <= wptr;
          wptr      <= wptr + W_TB_LEN'(1);
          pend_addr <= wptr;
          if (dec_last_i) begin
            pending    <= 1'b1;
            pend_end   <= 1'b1;
            pend_state <= '0;
            pend_len   <= und_next;
            und_cnt    <= und_next;
          end else if (und_next == LW'(TB_LEN)) begin
            pending    <= 1'b1;
            pend_end   <= 1'b0;
            pend_state <= best_state_i;
            pend_len   <= LW'(TB_LEN);
            und_cnt    <= und_next - LW'(TB_LEN / 2);
          end else begin
            und_cnt <= und_next;
          end
        end else begin
          chunk_cnt <= chunk_cnt + 3'd1;
          word      <= word_next;
        end
      end
      if (launch) begin
        pending    <= 1'b0;
        held_state <= pend_state;
        held_addr  <= pend_addr;
        held_len   <= pend_len;
        held_end   <= pend_end;
        if (pend_end) begin
          wptr      <= '0;
          chunk_cnt <= '0;
          und_cnt   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_tb_mem_writer.sv
// Scoreboard bench for tb_mem_writer: a reference model queues expected RAM writes and
// segment launches as chunks are driven; a negedge monitor pops and compares them.
module tb_tb_mem_writer;

  logic        clk_i = 1'b0;
  logic        rst_an_i, rst_sync_i, frame_start_i;
  logic [1:0]  register_num_i;
  logic        dec_valid_i, dec_last_i, tb_busy_i;
  logic [7:0]  dec_i;
  logic [5:0]  best_state_i;
  logic        dec_ready_o, wr_o, segment_start_o, decodeing_end_o;
  logic [5:0]  waddr_o, start_state_index_o, tb_start_addr_o;
  logic [63:0] wdata_o;
  logic [6:0]  tb_len_o;

  tb_mem_writer dut (
    .clk_i(clk_i), .rst_an_i(rst_an_i), .rst_sync_i(rst_sync_i),
    .frame_start_i(frame_start_i), .register_num_i(register_num_i),
    .dec_valid_i(dec_valid_i), .dec_i(dec_i), .dec_last_i(dec_last_i),
    .best_state_i(best_state_i), .dec_ready_o(dec_ready_o), .wr_o(wr_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .tb_busy_i(tb_busy_i),
    .segment_start_o(segment_start_o), .start_state_index_o(start_state_index_o),
    .tb_start_addr_o(tb_start_addr_o), .tb_len_o(tb_len_o),
    .decodeing_end_o(decodeing_end_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [5:0]  addr;
    logic [63:0] data;
  } wr_exp_t;

  wr_exp_t     wq[$];
  logic [19:0] sq[$];   // {start_addr, len, end, start_state}
  int          n_checks = 0;
  int          n_errors = 0;
  logic [5:0]  m_wptr;
  logic [6:0]  m_und;
  logic [1:0]  m_reg;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    wr_exp_t     we;
    logic [19:0] se;
    if (rst_an_i) begin
      if (wr_o) begin
        if (wq.size() == 0) chk("wr_unexpected", 1, 0);
        else begin
          we = wq.pop_front();
          chk("waddr", 64'(waddr_o), 64'(we.addr));
          chk("wdata", wdata_o, we.data);
        end
      end
      if (segment_start_o) begin
        if (sq.size() == 0) chk("seg_unexpected", 1, 0);
        else begin
          se = sq.pop_front();
          chk("seg_fields", 64'({tb_start_addr_o, tb_len_o, decodeing_end_o,
                                 start_state_index_o}), 64'(se));
        end
      end
    end
  end

  // Called and returns at posedge+1; the chunk is held until accepted.
  task automatic send_chunk(input logic [7:0] d, input bit last, input logic [5:0] best);
    int t = 0;
    dec_valid_i  = 1'b1;
    dec_i        = d;
    dec_last_i   = last;
    best_state_i = best;
    while (!dec_ready_o && t < 300) begin
      @(posedge clk_i); #1;
      t++;
    end
    if (t >= 300) chk("ready_timeout", 0, 1);
    @(posedge clk_i); #1;
    dec_valid_i = 1'b0;
    dec_last_i  = 1'b0;
  endtask

  task automatic send_step(input logic [63:0] data, input bit last, input logic [5:0] best);
    int         n = 8 >> m_reg;
    logic [63:0] w = '0;
    logic [6:0]  un;
    for (int k = 0; k < n; k++) w[8*k +: 8] = data[8*k +: 8];
    wq.push_back({m_wptr, w});
    un = m_und + 7'd1;
    if (last) begin
      sq.push_back({m_wptr, un, 1'b1, 6'd0});
      m_wptr = '0;
      m_und  = '0;
    end else begin
      if (un == 7'd32) begin
        sq.push_back({m_wptr, 7'd32, 1'b0, best});
        un = un - 7'd16;
      end
      m_und  = un;
      m_wptr = m_wptr + 6'd1;
    end
    for (int k = 0; k < n; k++) send_chunk(data[8*k +: 8], last, best);
  endtask

  task automatic new_frame(input logic [1:0] r);
    frame_start_i  = 1'b1;
    register_num_i = r;
    @(posedge clk_i); #1;
    frame_start_i = 1'b0;
    m_reg  = r;
    m_wptr = '0;
    m_und  = '0;
  endtask

  task automatic run_steps(input int cnt, input bit last_tag, input logic [5:0] best);
    for (int s = 0; s < cnt; s++)
      send_step({$urandom, $urandom}, last_tag && (s == cnt - 1), best);
  endtask

  task automatic idle(input int cyc);
    repeat (cyc) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    rst_an_i = 1'b0; rst_sync_i = 1'b0; frame_start_i = 1'b0; register_num_i = 2'b00;
    dec_valid_i = 1'b0; dec_i = '0; dec_last_i = 1'b0; best_state_i = '0; tb_busy_i = 1'b0;
    m_reg = 2'b00; m_wptr = '0; m_und = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ready", 64'(dec_ready_o), 1);
    chk("rst_wr", 64'(wr_o), 0);
    chk("rst_seg", 64'(segment_start_o), 0);
    chk("rst_waddr", 64'(waddr_o), 0);
    chk("rst_wdata", wdata_o, 0);
    chk("rst_fields", 64'({start_state_index_o, tb_start_addr_o, tb_len_o, decodeing_end_o}), 0);
    rst_an_i = 1'b1;
    @(posedge clk_i); #1;

    new_frame(2'b00);
    send_step(64'h0807060504030201, 1'b0, 6'd0);
    new_frame(2'b11);
    send_step(64'h00000000000000A5, 1'b0, 6'd0);
    new_frame(2'b10);
    send_step(64'hFFFFFFFFFFFFFFFF, 1'b0, 6'd0);
    idle(3);

    // 70 steps across the address wrap: segments at 31, 47, 63 (launched under busy), final at 5
    new_frame(2'b00);
    run_steps(48, 1'b0, 6'd17);
    run_steps(15, 1'b0, 6'd9);
    tb_busy_i = 1'b1;
    run_steps(1, 1'b0, 6'd9);
    fork
      begin
        for (int c = 0; c < 10; c++) begin
          chk("ready_low_busy", 64'(dec_ready_o), 0);
          chk("no_launch_busy", 64'(segment_start_o), 0);
          @(posedge clk_i); #1;
        end
        tb_busy_i = 1'b0;
        #1;
        chk("launch_on_drop", 64'(segment_start_o), 1);
      end
      run_steps(1, 1'b0, 6'd3);
    join
    run_steps(5, 1'b1, 6'd3);
    idle(3);
    run_steps(1, 1'b0, 6'd0);   // counters cleared by the final launch: write lands at 0
    idle(3);

    new_frame(2'b00);
    run_steps(40, 1'b1, 6'd21);
    idle(3);

    // Mid-frame restart while a segment is held pending: it must never launch
    new_frame(2'b01);
    tb_busy_i = 1'b1;
    run_steps(32, 1'b0, 6'd5);
    idle(2);
    new_frame(2'b00);
    sq.delete();
    tb_busy_i = 1'b0;
    idle(5);
    run_steps(32, 1'b0, 6'd44);
    idle(5);

    chk("wr_queue_drained", 64'(wq.size()), 0);
    chk("seg_queue_drained", 64'(sq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
